// File: rtl/add8_multiword_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : add8_multiword_ctrl_pkg
// Brief  : Shared types and constants for the multi-word adder sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package add8_multiword_ctrl_pkg;

   // Width of one slice handled by the external adder per cycle
   localparam int BYTE_W = 8;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : add8_multiword_ctrl_pkg
`default_nettype wire

// File: rtl/ADD_8.sv
`default_nettype none
// ============================================================================
// Module : ADD_8
// Brief  : 8-bit carry-lookahead adder (combinational datapath slice).
// Rev    : 1.0  initial release
// ============================================================================
module ADD_8 (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_cin,
   output logic [7:0] o_sum,
   output logic       o_co
);

   logic [7:0] w_g;
   logic [7:0] w_p;
   logic [8:0] w_c;
   logic       w_acc;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Each carry is expanded from g/p/cin only, so no carry depends on another
   always_comb begin
      w_c    = '0;
      w_acc  = 1'b0;
      w_c[0] = i_cin;
      for (int i = 1; i <= 8; i++) begin
         w_acc = i_cin;
         for (int j = 0; j < i; j++) begin
            w_acc = w_g[j] | (w_p[j] & w_acc);
         end
         w_c[i] = w_acc;
      end
   end

   assign o_sum = w_p ^ w_c[7:0];
   assign o_co  = w_c[8];

endmodule : ADD_8
`default_nettype wire

// File: rtl/add8_multiword_ctrl.sv
`default_nettype none
// ============================================================================
// Module : add8_multiword_ctrl
// Brief  : Time-multiplexes one external 8-bit adder to perform a WORDS-byte
//          add/subtract, LSB first, carry chained through a register.
// Rev    : 1.0  initial release
// ============================================================================
module add8_multiword_ctrl
   import add8_multiword_ctrl_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    sub,
   input  logic                    cin_in,
   input  logic [BYTE_W*WORDS-1:0] op_a,
   input  logic [BYTE_W*WORDS-1:0] op_b,
   output logic                    busy,
   output logic                    done,
   output logic [BYTE_W*WORDS-1:0] result,
   output logic                    cout,
   output logic                    ovf,
   output logic [BYTE_W-1:0]       add_a,
   output logic [BYTE_W-1:0]       add_b,
   output logic                    add_cin,
   input  logic [BYTE_W-1:0]       add_sum,
   input  logic                    add_co
);

   localparam int                 c_W        = BYTE_W * WORDS;
   localparam int                 c_IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [c_W-1:0]     r_a;
   logic [c_W-1:0]     r_b_eff;
   logic [c_W-1:0]     r_result;
   logic [c_IDX_W-1:0] r_idx;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic [c_W-1:0]     w_a_shift;
   logic [c_W-1:0]     w_b_shift;
   logic               w_run;
   logic               w_last;
   logic               w_accept;

   assign w_run    = (r_state == ST_RUN);
   assign w_last   = (r_idx == c_LAST_IDX);
   assign w_accept = (r_state == ST_IDLE) && start;

   // Byte selection for the adder; driven from registers only
   assign w_a_shift = r_a     >> (BYTE_W * int'(r_idx));
   assign w_b_shift = r_b_eff >> (BYTE_W * int'(r_idx));

   assign add_a   = w_run ? w_a_shift[BYTE_W-1:0] : '0;
   assign add_b   = w_run ? w_b_shift[BYTE_W-1:0] : '0;
   assign add_cin = w_run ? r_carry : 1'b0;

   assign busy   = (r_state != ST_IDLE);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after last byte
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: if (start)  w_state_next = ST_RUN;
         ST_RUN:  if (w_last) w_state_next = ST_DONE;
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Operand capture, per-byte result collection and carry chaining
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b_eff  <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_a      <= op_a;
         r_b_eff  <= sub ? ~op_b : op_b;
         r_carry  <= sub | cin_in;
         r_idx    <= '0;
         r_result <= '0;
      end else if (w_run) begin
         for (int i = 0; i < WORDS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
               r_result[i*BYTE_W +: BYTE_W] <= add_sum;
            end
         end
         r_carry <= add_co;
         if (w_last) begin
            // Index is held at the last byte rather than wrapping
            r_cout <= add_co;
            r_ovf  <= (r_a[c_W-1] == r_b_eff[c_W-1]) &&
                      (add_sum[BYTE_W-1] != r_a[c_W-1]);
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

endmodule : add8_multiword_ctrl
`default_nettype wire

// File: tb/tb_add8_multiword_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_add8_multiword_ctrl
// Brief  : Self-checking bench for add8_multiword_ctrl with a sibling ADD_8.
// Rev    : 1.0  initial release
// ============================================================================
module tb_add8_multiword_ctrl;

   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic         cin_in;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic [7:0]   add_a;
   logic [7:0]   add_b;
   logic         add_cin;
   logic [7:0]   add_sum;
   logic         add_co;

   int checks = 0;
   int errors = 0;

   add8_multiword_ctrl #(.WORDS(WORDS)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .sub     (sub),
      .cin_in  (cin_in),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .cout    (cout),
      .ovf     (ovf),
      .add_a   (add_a),
      .add_b   (add_b),
      .add_cin (add_cin),
      .add_sum (add_sum),
      .add_co  (add_co)
   );

   ADD_8 u_add (
      .i_a   (add_a),
      .i_b   (add_b),
      .i_cin (add_cin),
      .o_sum (add_sum),
      .o_co  (add_co)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain unsigned / signed arithmetic on whole operands
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit s, input bit ci,
                        output logic [W-1:0] r, output bit co, output bit ov);
      longint ua, ub, sa, sb, t, sr;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         t  = ua - ub;
         co = (ua >= ub);
         sr = sa - sb;
      end else begin
         t  = ua + ub + longint'(ci);
         co = (t >= 64'h1_0000_0000);
         sr = sa + sb + longint'(ci);
      end
      r  = t[W-1:0];
      ov = (sr != longint'($signed(r)));
   endtask

   task automatic run_job(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit s, input bit ci, input bit poke);
      logic [W-1:0] exp_r;
      bit           exp_co;
      bit           exp_ov;
      logic [7:0]   b0;
      model(a, b, s, ci, exp_r, exp_co, exp_ov);
      b0 = s ? ~b[7:0] : b[7:0];
      @(negedge clk);
      op_a   = a;
      op_b   = b;
      sub    = s;
      cin_in = ci;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      op_a   = $urandom;
      op_b   = $urandom;
      sub    = 1'($urandom);
      cin_in = 1'($urandom);
      chk({tag, "_busy_accept"}, busy, 1);
      chk({tag, "_result_clear"}, result, 0);
      chk({tag, "_add_a0"}, add_a, a[7:0]);
      chk({tag, "_add_b0"}, add_b, b0);
      chk({tag, "_add_cin0"}, add_cin, s | ci);
      for (int k = 1; k <= WORDS; k++) begin
         if (poke && k == 2) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         chk({tag, "_done_timing"}, done, (k == WORDS));
         chk({tag, "_busy_run"}, busy, 1);
      end
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_cout"}, cout, exp_co);
      chk({tag, "_ovf"}, ovf, exp_ov);
      if (poke) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_done"}, done, 0);
      chk({tag, "_result_held"}, result, exp_r);
      chk({tag, "_idle_add_a"}, add_a, 0);
      chk({tag, "_idle_add_cin"}, add_cin, 0);
      if (poke) begin
         @(posedge clk);
         #1;
         chk({tag, "_poke_ignored"}, busy, 0);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      sub    = 1'b0;
      cin_in = 1'b0;
      op_a   = '0;
      op_b   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_add_cin", add_cin, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed jobs, issued back-to-back
      run_job("t1_ff_plus_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run_job("t2_ripple_all",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run_job("t3_sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
      run_job("t3_sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
      run_job("t4_add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run_job("t4_add_cin",     32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
      run_job("t5_busy_poke",   32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0, 1'b1);
      run_job("t5_after_poke",  32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b0);

      // Reset during the second RUN cycle
      @(negedge clk);
      op_a   = 32'hFFFF_FF11;
      op_b   = 32'h0000_0001;
      sub    = 1'b0;
      cin_in = 1'b0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_partial_written", result[7:0], 8'h12);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_result", result, 0);
      chk("t6_rst_cout", cout, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_add_a", add_a, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("t6_no_done_in_rst", done, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < WORDS + 1; k++) begin
         @(posedge clk);
         #1;
         chk("t6_no_done_after", done, 0);
      end
      run_job("t6_fresh", 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1, 1'b0);

      // Randomized jobs
      for (int n = 0; n < 24; n++) begin
         run_job("rnd", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                 (n % 5) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_add8_multiword_ctrl
`default_nettype wire

// File: doc/add8_multiword_ctrl.md
Name: add8_multiword_ctrl

Overview:
Sequencer that performs WORDS-byte add/subtract by time-multiplexing one external 8-bit carry-lookahead adder (the team's ADD_8 datapath), least-significant byte first, with the carry chained through a register. It sits between a requesting unit (start/done handshake) and a single adder instance. The adder is kept outside this block so that it can later be shared under an arbiter.

Parameters:
WORDS, 4, number of 8-bit bytes per operand (>=2); operand width W = 8*WORDS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
sub  in  1  1 = A-B (two's complement), 0 = A+B+cin_in
cin_in  in  1  carry-in for add; ignored when sub=1
op_a  in  W  operand A; captured on accepted start
op_b  in  W  operand B; captured on accepted start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; result valid
result  out  W  sum/difference; held until next accepted start
cout  out  1  final carry out (sub: 1 = no borrow)
ovf  out  1  signed overflow
add_a  out  8  to adder A
add_b  out  8  to adder B
add_cin  out  1  to adder Cin
add_sum  in  8  from adder Sum
add_co  in  1  from adder CO

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; busy=0; done=0; result=0; cout=0; ovf=0; idx=0; carry=0. add_a, add_b and add_cin are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: when start=1 at an edge:
  - latch op_a and op_b;
  - latch b_eff = sub ? ~op_b : op_b;
  - carry <= sub ? 1 : cin_in;
  - idx <= 0; result <= 0;
  - go to RUN.
- RUN: add_a = A[8*idx+:8], add_b = b_eff[8*idx+:8], add_cin = carry. These are combinational from registers only; there is no path from add_sum to add_a.
- RUN, each edge: result[8*idx+:8] <= add_sum; carry <= add_co; idx <= idx+1.
  - At idx = WORDS-1: cout <= add_co; ovf <= (A[W-1] == b_eff[W-1]) && (add_sum[7] != A[W-1]); go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Adder outputs are 0 outside RUN.
- Latency: start sampled at edge T; byte results captured at edges T+1..T+WORDS; done high in the cycle after edge T+WORDS; busy falls at edge T+WORDS+1.
- Throughput: a new start is accepted in the cycle after done (back-to-back: one job per WORDS+2 cycles).
- start while busy is ignored, with no queueing. op_a and op_b may change freely after acceptance.
- Combinational adder delay must fit within one clk period; the block adds no cycle for it.
- Reset mid-RUN: immediate return to IDLE with all outputs cleared; no done pulse; the partial result is discarded.
- idx is $clog2(WORDS) bits wide and never wraps within a job.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, RUN, DONE);
  - constant BYTE_W = 8.
- No sub-module. The ADD_8 instance is a sibling, wired by the parent.
- The testbench instantiates ADD_8 alongside this block.

Test Plan:
1. WORDS=4, add, A=0x000000FF, B=0x00000001, cin_in=0 -> result=0x00000100, cout=0, ovf=0; done exactly 4 cycles after the start edge.
2. Add, A=0xFFFFFFFF, B=0x00000001 -> result=0x00000000, cout=1, ovf=0 (carry ripples through all bytes).
3. sub=1, A=0x00000005, B=0x00000007 -> result=0xFFFFFFFE, cout=0 (borrow), ovf=0. Also A=0x80000000, B=0x00000001 -> result=0x7FFFFFFF, ovf=1.
4. Add, A=0x7FFFFFFF, B=0x00000001 -> result=0x80000000, ovf=1, cout=0. Then A=0x12345678, B=0x11111111, cin_in=1 -> result=0x2345678A.
5. Assert start with different operands while busy -> ignored; the first job's result and done timing are unchanged. A start in the cycle after done is accepted.
6. Drop rst_n during the 2nd RUN cycle -> busy, result, cout and done all go to 0 immediately; no done pulse follows. A fresh job after release gives the correct result.
